// File: rtl/core_pkg.sv
// Shared core definitions: fetch FSM states, instruction size, default reset PC.
package core_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD
  } fetch_state_e;

  localparam int unsigned INST_BYTES       = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus.
// Ports: req/addr (fetch request), gnt (request accepted),
//        rvalid/rdata (response word).
interface fetch_unit_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);

  logic          req;
  logic [AW-1:0] addr;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );

endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit.
// Ports: clk, rst (sync active-high); imem (fetch bus master);
//        redirect_valid/redirect_pc (branch/jump target);
//        inst_valid/inst_ready handshake towards decode;
//        inst/inst_pc (held word and its address);
//        opcode/func3/func7 (decoded fields, zero when nothing is held).
module fetch_unit
  import core_pkg::*;
#(
  parameter int unsigned   AW       = 32,
  parameter int unsigned   DW       = 32,
  parameter logic [AW-1:0] RESET_PC = AW'(DEFAULT_RESET_PC)
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  imem,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [DW-1:0] inst,
  output logic [AW-1:0] inst_pc,
  output logic [6:0]    opcode,
  output logic [2:0]    func3,
  output logic [6:0]    func7
);

  fetch_state_e  state, state_n;
  logic [AW-1:0] pc, pc_n;
  logic          discard, discard_n;
  logic [DW-1:0] inst_n;
  logic [AW-1:0] inst_pc_n;

  // Redirect targets are word aligned; the low bits are deliberately dropped.
  logic [1:0] unused_redirect_lsb;
  assign unused_redirect_lsb = redirect_pc[1:0];

  // State, PC and instruction registers; every output is a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      discard    <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
      imem.req   <= 1'b1;
      imem.addr  <= RESET_PC;
      opcode     <= '0;
      func3      <= '0;
      func7      <= '0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      discard    <= discard_n;
      inst       <= inst_n;
      inst_pc    <= inst_pc_n;
      inst_valid <= (state_n == HOLD);
      imem.req   <= (state_n == IDLE);
      imem.addr  <= pc_n;
      opcode     <= (state_n == HOLD) ? inst_n[6:0]   : 7'd0;
      func3      <= (state_n == HOLD) ? inst_n[14:12] : 3'd0;
      func7      <= (state_n == HOLD) ? inst_n[31:25] : 7'd0;
    end
  end

  // Next-state logic; a redirect always wins the PC and poisons any in-flight response.
  always_comb begin
    state_n   = state;
    pc_n      = pc;
    discard_n = discard;
    inst_n    = inst;
    inst_pc_n = inst_pc;

    case (state)
      IDLE: begin
        if (imem.gnt) begin
          state_n   = WAIT;
          discard_n = redirect_valid;
        end
      end
      WAIT: begin
        if (imem.rvalid) begin
          state_n   = IDLE;
          discard_n = 1'b0;
          if (!discard && !redirect_valid) begin
            state_n   = HOLD;
            inst_n    = imem.rdata;
            inst_pc_n = pc;
            pc_n      = pc + AW'(INST_BYTES);
          end
        end else if (redirect_valid) begin
          discard_n = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_valid || inst_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (redirect_valid) begin
      pc_n = {redirect_pc[AW-1:2], 2'b00};
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a transaction-level reference model.
module tb_fetch_unit;
  import core_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          inst_valid;
  logic          inst_ready;
  logic [DW-1:0] inst;
  logic [AW-1:0] inst_pc;
  logic [6:0]    opcode;
  logic [2:0]    func3;
  logic [6:0]    func7;

  int checks = 0;
  int errors = 0;

  fetch_unit_if #(.AW(AW), .DW(DW)) imem ();

  fetch_unit #(.AW(AW), .DW(DW), .RESET_PC(RPC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem           (imem),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .opcode         (opcode),
    .func3          (func3),
    .func7          (func7)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of granted requests, each marked live or killed by a redirect.
  typedef struct {
    logic [31:0] addr;
    bit          live;
  } req_t;

  req_t        pend[$];
  logic [31:0] m_pc   = RPC;
  bit          m_held = 1'b0;
  logic [31:0] m_inst = '0;
  logic [31:0] m_ipc  = '0;

  always @(posedge clk) begin
    req_t r;
    if (rst) begin
      pend.delete();
      m_pc   = RPC;
      m_held = 1'b0;
      m_inst = '0;
      m_ipc  = '0;
    end else begin
      if (m_held) begin
        if (redirect_valid || inst_ready) m_held = 1'b0;
      end else if (pend.size() > 0) begin
        if (imem.rvalid) begin
          r = pend.pop_front();
          if (r.live && !redirect_valid) begin
            m_held = 1'b1;
            m_inst = imem.rdata;
            m_ipc  = r.addr;
            m_pc   = r.addr + 32'd4;
          end
        end
      end else if (imem.gnt) begin
        pend.push_back('{addr: m_pc, live: 1'b1});
      end
      if (redirect_valid) begin
        foreach (pend[i]) pend[i].live = 1'b0;
        m_pc = {redirect_pc[31:2], 2'b00};
      end
    end

    #1;
    chk("req", 32'(imem.req), 32'((pend.size() == 0) && !m_held));
    if (imem.req) chk("addr", imem.addr, m_pc);
    chk("inst_valid", 32'(inst_valid), 32'(m_held));
    if (m_held || rst) begin
      chk("inst", inst, m_inst);
      chk("inst_pc", inst_pc, m_ipc);
    end
    chk("opcode", 32'(opcode), m_held ? 32'(m_inst[6:0])   : 32'd0);
    chk("func3",  32'(func3),  m_held ? 32'(m_inst[14:12]) : 32'd0);
    chk("func7",  32'(func7),  m_held ? 32'(m_inst[31:25]) : 32'd0);
  end

  // Apply one cycle of inputs starting at a falling edge.
  task automatic step(input bit g, input bit rv, input logic [31:0] rd,
                      input bit rdr, input logic [31:0] rp, input bit rdy);
    imem.gnt       = g;
    imem.rvalid    = rv;
    imem.rdata     = rd;
    redirect_valid = rdr;
    redirect_pc    = rp;
    inst_ready     = rdy;
    @(negedge clk);
  endtask

  initial begin
    rst            = 1'b1;
    imem.gnt       = 1'b0;
    imem.rvalid    = 1'b0;
    imem.rdata     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'd0);
    rst = 1'b0;
    chk("first_req", 32'(imem.req), 32'd1);
    chk("first_addr", imem.addr, RPC);

    // Basic fetch.
    step(1, 0, 0, 0, 0, 0);
    chk("wait_req", 32'(imem.req), 32'd0);
    step(0, 1, 32'h0000_0033, 0, 0, 0);
    chk("hold_valid", 32'(inst_valid), 32'd1);
    chk("hold_pc0", inst_pc, 32'h0);
    chk("hold_op33", 32'(opcode), 32'h33);
    step(0, 0, 0, 0, 0, 1);
    chk("next_addr4", imem.addr, 32'h4);

    // Decode stall for 5 cycles.
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'h40A5_8233, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0, 0, 0);
    chk("stall_inst", inst, 32'h40A5_8233);
    chk("stall_pc", inst_pc, 32'h4);
    chk("stall_f7", 32'(func7), 32'h20);
    chk("stall_req", 32'(imem.req), 32'd0);
    step(0, 0, 0, 0, 0, 1);
    chk("resume_addr8", imem.addr, 32'h8);

    // Redirect while waiting; response dropped.
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h0000_0102, 0);
    step(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
    chk("drop_valid", 32'(inst_valid), 32'd0);
    chk("redir_addr100", imem.addr, 32'h100);

    // Redirect coincident with grant.
    step(1, 0, 0, 1, 32'h0000_0200, 0);
    step(0, 1, 32'hCAFE_0013, 0, 0, 0);
    chk("gnt_redir_valid", 32'(inst_valid), 32'd0);
    chk("gnt_redir_addr", imem.addr, 32'h200);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'h0000_0013, 0, 0, 0);
    chk("after_redir_pc", inst_pc, 32'h200);
    step(0, 0, 0, 0, 0, 1);

    // Stray response in IDLE is ignored.
    step(0, 1, 32'h1234_5678, 0, 0, 0);
    chk("idle_rvalid_req", 32'(imem.req), 32'd1);
    chk("idle_rvalid_addr", imem.addr, 32'h204);

    // Address wrap.
    step(0, 0, 0, 1, 32'hFFFF_FFFF, 0);
    chk("wrap_addr", imem.addr, 32'hFFFF_FFFC);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'h0000_006F, 0, 0, 0);
    chk("wrap_pc", inst_pc, 32'hFFFF_FFFC);
    step(0, 1, 32'h0000_0055, 0, 0, 0);
    chk("hold_rvalid_inst", inst, 32'h0000_006F);
    step(0, 0, 0, 0, 0, 1);
    chk("wrap_next0", imem.addr, 32'h0);

    // Redirect in HOLD together with accept.
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'h0010_0093, 0, 0, 0);
    step(0, 0, 0, 1, 32'h0000_0040, 1);
    chk("hold_redir_valid", 32'(inst_valid), 32'd0);
    chk("hold_redir_addr", imem.addr, 32'h40);

    // Redirect coincident with response.
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'h0000_0011, 1, 32'h0000_0080, 0);
    chk("rv_redir_valid", 32'(inst_valid), 32'd0);
    chk("rv_redir_addr", imem.addr, 32'h80);

    // Repeated redirects while discarding.
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h0000_0300, 0);
    step(0, 0, 0, 1, 32'h0000_0400, 0);
    chk("multi_redir_req", 32'(imem.req), 32'd0);
    step(0, 1, 32'h0000_0022, 0, 0, 0);
    chk("multi_redir_addr", imem.addr, 32'h400);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'h0000_0033, 0, 0, 0);
    chk("multi_redir_pc", inst_pc, 32'h400);
    step(0, 0, 0, 0, 0, 1);

    // Reset while waiting; late response ignored.
    step(1, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h0000_0077, 0, 0, 0);
    chk("rst_wait_valid", 32'(inst_valid), 32'd0);
    chk("rst_wait_req", 32'(imem.req), 32'd1);
    chk("rst_wait_addr", imem.addr, RPC);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter AW, default 32: instruction address width.
REQ-002 Parameter DW, default 32: instruction word width.
REQ-003 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock, all state on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 imem_req  out  1  fetch request valid.
REQ-008 imem_addr  out  AW  fetch byte address, bits [1:0] always 0.
REQ-009 imem_gnt  in  1  memory accepts request this cycle.
REQ-010 imem_rvalid  in  1  response data valid.
REQ-011 imem_rdata  in  DW  instruction word.
REQ-012 redirect_valid  in  1  branch/jump taken.
REQ-013 redirect_pc  in  AW  new fetch target, bits [1:0] ignored.
REQ-014 inst_valid  out  1  instruction available to decode.
REQ-015 inst_ready  in  1  decode/controller accepts instruction.
REQ-016 inst  out  DW  held instruction word.
REQ-017 inst_pc  out  AW  address of held instruction.
REQ-018 opcode/func3/func7  out  7/3/7  inst[6:0], inst[14:12], inst[31:25]; all-zero when inst_valid=0.

Function
REQ-019 FSM states IDLE, WAIT, HOLD; at most one outstanding memory request.
REQ-020 IDLE: imem_req=1, imem_addr=pc; on imem_gnt -> WAIT.
REQ-021 WAIT: imem_req=0; on imem_rvalid capture imem_rdata and pc into inst/inst_pc, pc <= pc+4 -> HOLD.
REQ-022 HOLD: inst_valid=1; on inst_valid&&inst_ready -> IDLE; inst/inst_pc stable until then.
REQ-023 Latency: inst_valid rises the cycle after imem_rvalid; imem_req rises the cycle after handshake.
REQ-024 pc+4 wraps modulo 2^AW (e.g. 32'hFFFF_FFFC -> 32'h0).
REQ-025 redirect_valid has priority: pc <= {redirect_pc[AW-1:2],2'b00} regardless of state.
REQ-026 Redirect in IDLE without gnt -> stay IDLE at new pc; with gnt same cycle -> WAIT with discard=1.
REQ-027 Redirect in WAIT without rvalid -> set discard=1; with rvalid same cycle -> drop data -> IDLE.
REQ-028 WAIT with discard=1: next imem_rvalid dropped, discard cleared -> IDLE; inst_valid stays 0.
REQ-029 Redirect in HOLD -> IDLE, inst_valid=0 next cycle; if inst_ready same cycle, handshake counts as completed.
REQ-030 Repeated redirects while discard=1: pc updates to latest target, discard stays 1.
REQ-031 imem_rvalid in IDLE or HOLD is ignored.

Reset
REQ-032 On rst: state=IDLE, pc=RESET_PC, discard=0, inst_valid=0, inst=0, inst_pc=0.
REQ-033 imem_req=1 with imem_addr=RESET_PC in first cycle after rst deasserts.
REQ-034 rst mid-WAIT abandons the outstanding request; late rvalid is ignored per REQ-031.

Structure
REQ-035 Shared package core_pkg holds fetch_state_e enum (IDLE/WAIT/HOLD), INST_BYTES=4, default RESET_PC.
REQ-036 No sub-module; one flat module, FSM plus pc, discard and instruction registers.

Verification
REQ-037 Reset, gnt=1, rvalid 1 cycle later with 32'h0000_0033, inst_ready=1 -> imem_addr 0, inst_valid with inst_pc=0, opcode=7'h33; next fetch addr 4.
REQ-038 inst_ready=0 for 5 cycles in HOLD -> inst/inst_pc stable, imem_req=0 throughout; accept -> fetch resumes at pc+4.
REQ-039 Redirect to 32'h0000_0102 while in WAIT; rvalid next cycle -> data dropped, next imem_addr 32'h0000_0100.
REQ-040 Redirect coincident with gnt in IDLE -> first response dropped, following request to redirect target.
REQ-041 pc=32'hFFFF_FFFC fetched and accepted -> next imem_addr 32'h0000_0000.
REQ-042 rst asserted in WAIT, rvalid arrives 2 cycles later -> ignored, fetch restarts at RESET_PC, inst_valid=0.
